dsa_simd_write_packer: RTL and testbench
========================================

Name: dsa_simd_write_packer

Overview:
- Initiator for the 4-bank DSA memory write side.
- Accepts a stream of output pixels, one per cycle, from the interpolation datapath over valid/ready.
- Packs aligned groups of 4 pixels into one SIMD write: simd_write_en, simd_base_addr, simd_data_0..3.
- Emits unaligned head pixels and the short tail as single writes (write_en/write_addr/write_data), so any base address and pixel count are handled.

Parameters:
- ADDR_WIDTH, 18, byte address width of the target memory.
- CNT_WIDTH, 19, width of the pixel count (ADDR_WIDTH+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches base_addr and num_pixels when idle
- base_addr  in  ADDR_WIDTH  first destination byte address; any alignment
- num_pixels  in  CNT_WIDTH  pixels in the transfer; 0 is legal
- pix_valid  in  1  input pixel valid
- pix_data  in  8  input pixel
- pix_ready  out  1  packer accepts pix_data this cycle
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when transfer complete
- write_en  out  1  single-byte write strobe
- write_addr  out  ADDR_WIDTH  single write address
- write_data  out  8  single write data
- simd_write_en  out  1  4-lane write strobe
- simd_base_addr  out  ADDR_WIDTH  group address, always with [1:0]==0
- simd_data_0..simd_data_3  out  8 each  lanes for banks 0..3

Behaviour:
- Reset (async, rst_n low): all outputs 0; state IDLE; lane buffer, counters and address cleared. Reset mid-transfer abandons the transfer: no further strobes, no done.
- States:
  - IDLE: start loads cur_addr=base_addr, remaining=num_pixels, lane=0. Go RUN, or FINISH if num_pixels==0.
  - RUN: pix_ready = (remaining!=0).
  - FINISH: done pulses for 1 cycle, then IDLE.
- start is ignored outside IDLE.
- busy is high in RUN and FINISH; it is low in the cycle start is sampled.
- Accept = pix_valid && pix_ready. On each accept: cur_addr += 1, remaining -= 1.
- Per-accept classification, decided when lane==0:
  - GROUP if cur_addr[1:0]==0 and remaining>=4.
  - Otherwise SINGLE.
  - lane!=0 means the pixel continues the current group. Remaining>=4 at group start guarantees every group completes.
- SINGLE: in the next cycle write_en=1, write_addr=accepted address, write_data=pixel. Strobe lasts exactly 1 cycle.
- GROUP: the pixel is stored in lane buffer[cur_addr[1:0]] and lane increments mod 4.
  - On the 4th accept, in the next cycle: simd_write_en=1, simd_base_addr = group address with [1:0] cleared, simd_data_k = lane k.
- simd_write_en and write_en are never high in the same cycle.
- Data/address outputs hold their last value when the strobe is low.
- Accepts may be back-to-back. No backpressure from memory: pix_ready never drops mid-transfer except when remaining==0.
- Gaps in pix_valid stall the packer without losing a partial group.
- After the accept that makes remaining==0 (cycle N): final strobe in N+1, state FINISH in N+1, done in N+2.
- Address wraps modulo 2^ADDR_WIDTH; a group never straddles the wrap because groups are aligned.

Optional Feature:
- Macro WRPACK_PERF_EN.
- When defined: adds outputs simd_cnt and single_cnt, each 16 bits.
  - Cleared by reset and on each accepted start.
  - Each increments, saturating, on every simd_write_en / write_en strobe respectively.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. base_addr=0x00100, num_pixels=8, pixels 1..8 back-to-back.
   - Required: two simd_write_en pulses, addr 0x00100 data {1,2,3,4} and addr 0x00104 data {5,6,7,8}; no write_en; done 2 cycles after the 8th accept.
2. base_addr=0x00003, num_pixels=7, pixels A0..A6.
   - Required: single write 0x00003=A0; SIMD at 0x00004 {A1..A4}; singles 0x00008=A5, 0x00009=A6.
3. num_pixels=0.
   - Required: no strobes, pix_ready stays 0, done pulses once.
4. base_addr=0, num_pixels=4, pix_valid toggling 1/0 each cycle.
   - Required: single SIMD write at 0 with correct lanes, issued the cycle after the 4th accept.
5. rst_n asserted after 2 accepts of a group.
   - Required: outputs go 0 immediately, no SIMD write or done ever; a new start then behaves as in scenario 1.
6. With WRPACK_PERF_EN, run scenario 2.
   - Required: simd_cnt=1, single_cnt=3.
   - Then start again and check both counters clear to 0.

Source files
------------

// File: rtl/dsa_simd_write_packer_if.sv
// Pixel-stream and memory-write bundle for dsa_simd_write_packer.
// master drives start/config/pixels; slave is the packer.
interface dsa_simd_write_packer_if #(
   parameter int ADDR_WIDTH = 18,
   parameter int CNT_WIDTH  = 19
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [CNT_WIDTH-1:0]  num_pixels;
   logic                  pix_valid;
   logic [7:0]            pix_data;
   logic                  pix_ready;
   logic                  busy;
   logic                  done;
   logic                  write_en;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [7:0]            write_data;
   logic                  simd_write_en;
   logic [ADDR_WIDTH-1:0] simd_base_addr;
   logic [7:0]            simd_data_0;
   logic [7:0]            simd_data_1;
   logic [7:0]            simd_data_2;
   logic [7:0]            simd_data_3;

   modport master (
      output start, base_addr, num_pixels,
      output pix_valid, pix_data,
      input  pix_ready, busy, done,
      input  write_en, write_addr, write_data,
      input  simd_write_en, simd_base_addr,
      input  simd_data_0, simd_data_1,
      input  simd_data_2, simd_data_3
   );

   modport slave (
      input  start, base_addr, num_pixels,
      input  pix_valid, pix_data,
      output pix_ready, busy, done,
      output write_en, write_addr, write_data,
      output simd_write_en, simd_base_addr,
      output simd_data_0, simd_data_1,
      output simd_data_2, simd_data_3
   );
endinterface

// File: rtl/dsa_simd_write_packer.sv
// Packs aligned 4-pixel groups into SIMD writes, rest as single writes.
// Optional WRPACK_PERF_EN adds simd_cnt / single_cnt strobe counters.
module dsa_simd_write_packer #(
   parameter int ADDR_WIDTH = 18,
   parameter int CNT_WIDTH  = 19
) (
   input  logic clk,
   input  logic rst_n,
   dsa_simd_write_packer_if.slave p
`ifdef WRPACK_PERF_EN
   ,
   output logic [15:0] simd_cnt,
   output logic [15:0] single_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [CNT_WIDTH-1:0]  remaining;
   logic [1:0]            lane;
   logic [7:0]            lane_buf [4];
   logic                  accept;
   logic                  grp_start;

   assign p.pix_ready = (state == RUN) && (remaining != '0);
   assign p.busy      = (state != IDLE);
   assign accept      = p.pix_valid && p.pix_ready;
   assign grp_start   = (lane == 2'd0) && (cur_addr[1:0] == 2'd0)
                     && (remaining >= CNT_WIDTH'(4));

   // Transfer FSM, lane packing and registered write strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         cur_addr         <= '0;
         remaining        <= '0;
         lane             <= '0;
         for (int i = 0; i < 4; i++) lane_buf[i] <= '0;
         p.done           <= 1'b0;
         p.write_en       <= 1'b0;
         p.write_addr     <= '0;
         p.write_data     <= '0;
         p.simd_write_en  <= 1'b0;
         p.simd_base_addr <= '0;
         p.simd_data_0    <= '0;
         p.simd_data_1    <= '0;
         p.simd_data_2    <= '0;
         p.simd_data_3    <= '0;
      end else begin
         p.done          <= 1'b0;
         p.write_en      <= 1'b0;
         p.simd_write_en <= 1'b0;
         unique case (state)
            IDLE: begin
               if (p.start) begin
                  cur_addr  <= p.base_addr;
                  remaining <= p.num_pixels;
                  lane      <= '0;
                  state     <= (p.num_pixels == '0) ? FINISH : RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  cur_addr  <= cur_addr + 1'b1;
                  remaining <= remaining - 1'b1;
                  if (remaining == CNT_WIDTH'(1)) state <= FINISH;
                  // lane!=0 means we are mid-group; the group always completes
                  if (lane != 2'd0 || grp_start) begin
                     lane_buf[cur_addr[1:0]] <= p.pix_data;
                     lane                    <= lane + 2'd1;
                     if (lane == 2'd3) begin
                        p.simd_write_en  <= 1'b1;
                        p.simd_base_addr <= {cur_addr[ADDR_WIDTH-1:2], 2'b00};
                        p.simd_data_0    <= lane_buf[0];
                        p.simd_data_1    <= lane_buf[1];
                        p.simd_data_2    <= lane_buf[2];
                        p.simd_data_3    <= p.pix_data;
                     end
                  end else begin
                     p.write_en   <= 1'b1;
                     p.write_addr <= cur_addr;
                     p.write_data <= p.pix_data;
                  end
               end
            end
            FINISH: begin
               p.done <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WRPACK_PERF_EN
   // Saturating strobe counters, cleared when a transfer is started.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         simd_cnt   <= '0;
         single_cnt <= '0;
      end else if (state == IDLE && p.start) begin
         simd_cnt   <= '0;
         single_cnt <= '0;
      end else begin
         if (p.simd_write_en && simd_cnt != 16'hFFFF)
            simd_cnt <= simd_cnt + 16'd1;
         if (p.write_en && single_cnt != 16'hFFFF)
            single_cnt <= single_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dsa_simd_write_packer.sv
// Bench for dsa_simd_write_packer: directed scenarios plus random
// transfers compared against a write-list model built from addresses.
module tb_dsa_simd_write_packer;
   localparam int AW = 18;
   localparam int CW = 19;

   typedef struct packed {
      logic          simd;
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dsa_simd_write_packer_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

`ifdef WRPACK_PERF_EN
   logic [15:0] simd_cnt;
   logic [15:0] single_cnt;
`endif

   dsa_simd_write_packer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .p          (bus.slave)
`ifdef WRPACK_PERF_EN
      ,
      .simd_cnt   (simd_cnt),
      .single_cnt (single_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   wr_t        obs_q[$];
   wr_t        exp_q[$];
   logic [7:0] pix_q[$];
   int         acc_cnt, last_acc_cyc, done_cnt, done_cyc;
   int         last_wr_cyc, both_cnt;
   int         exp_simd, exp_single;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: sample DUT outputs mid-cycle.
   always @(negedge clk) begin
      wr_t w;
      if (bus.pix_valid && bus.pix_ready) begin
         acc_cnt++;
         last_acc_cyc = cyc;
      end
      if (bus.write_en) begin
         w.simd = 1'b0;
         w.addr = bus.write_addr;
         w.data = {24'h0, bus.write_data};
         obs_q.push_back(w);
         last_wr_cyc = cyc;
      end
      if (bus.simd_write_en) begin
         w.simd = 1'b1;
         w.addr = bus.simd_base_addr;
         w.data = {bus.simd_data_3, bus.simd_data_2,
                   bus.simd_data_1, bus.simd_data_0};
         obs_q.push_back(w);
         last_wr_cyc = cyc;
      end
      if (bus.write_en && bus.simd_write_en) both_cnt++;
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic clear_mon();
      obs_q.delete();
      acc_cnt      = 0;
      done_cnt     = 0;
      both_cnt     = 0;
      last_acc_cyc = -1;
      last_wr_cyc  = -1;
      done_cyc     = -1;
   endtask

   // Reference: walk pixel indices; aligned address with >=4 left is a group.
   task automatic build_model(input logic [AW-1:0] base, input int n);
      int i;
      logic [AW-1:0] a;
      wr_t w;
      exp_q.delete();
      exp_simd   = 0;
      exp_single = 0;
      i = 0;
      while (i < n) begin
         a = base + AW'(i);
         if (a % 4 == 0 && n - i >= 4) begin
            w.simd = 1'b1;
            w.addr = a;
            w.data = {pix_q[i+3], pix_q[i+2], pix_q[i+1], pix_q[i]};
            exp_simd++;
            i += 4;
         end else begin
            w.simd = 1'b0;
            w.addr = a;
            w.data = {24'h0, pix_q[i]};
            exp_single++;
            i += 1;
         end
         exp_q.push_back(w);
      end
   endtask

   // mode: 0 back-to-back, 1 valid toggling, 2 random gaps
   task automatic run_xfer(input logic [AW-1:0] base, input int n,
                           input int mode, input string name);
      int k, guard, start_cyc, exp_done;
      clear_mon();
      build_model(base, n);
      @(posedge clk); #1;
      bus.start      = 1'b1;
      bus.base_addr  = base;
      bus.num_pixels = CW'(n);
      @(negedge clk);
      start_cyc = cyc;
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL %s busy_at_start: got %b want 0", name, bus.busy);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
`ifdef WRPACK_PERF_EN
      total++;
      if (simd_cnt !== 16'd0 || single_cnt !== 16'd0) begin
         bad++;
         $display("FAIL %s perf_clear: got %0d/%0d want 0/0",
                  name, simd_cnt, single_cnt);
      end
`endif
      k = 0;
      guard = 0;
      while (k < n && guard < 2000) begin
         case (mode)
            0:       bus.pix_valid = 1'b1;
            1:       bus.pix_valid = (guard % 2 == 0);
            default: bus.pix_valid = ($urandom_range(0, 3) != 0);
         endcase
         bus.pix_data = pix_q[k];
         @(negedge clk);
         if (bus.pix_valid && bus.pix_ready) k++;
         @(posedge clk); #1;
         guard++;
      end
      // Keep offering junk pixels: none may be taken once count is exhausted.
      bus.pix_valid = 1'b1;
      bus.pix_data  = 8'hEE;
      guard = 0;
      while (done_cnt == 0 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      repeat (3) @(posedge clk);
      #1;
      bus.pix_valid = 1'b0;

      total++;
      if (k != n) begin
         bad++;
         $display("FAIL %s feed: got %0d pixels taken want %0d", name, k, n);
      end
      total++;
      if (acc_cnt != n) begin
         bad++;
         $display("FAIL %s accepts: got %0d want %0d", name, acc_cnt, n);
      end
      total++;
      if (done_cnt != 1) begin
         bad++;
         $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
      end
      exp_done = (n == 0) ? start_cyc + 2 : last_acc_cyc + 2;
      total++;
      if (done_cyc != exp_done) begin
         bad++;
         $display("FAIL %s done_cycle: got %0d want %0d",
                  name, done_cyc, exp_done);
      end
      if (n > 0) begin
         total++;
         if (last_wr_cyc != last_acc_cyc + 1) begin
            bad++;
            $display("FAIL %s last_strobe_cycle: got %0d want %0d",
                     name, last_wr_cyc, last_acc_cyc + 1);
         end
      end
      total++;
      if (both_cnt != 0) begin
         bad++;
         $display("FAIL %s dual_strobe: got %0d cycles want 0", name, both_cnt);
      end
      total++;
      if (obs_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL %s write_count: got %0d want %0d",
                  name, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         total++;
         if (i >= obs_q.size()) begin
            bad++;
            $display("FAIL %s write[%0d]: got none want %0h", name, i, exp_q[i]);
         end else if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL %s write[%0d]: got %0h want %0h",
                     name, i, obs_q[i], exp_q[i]);
         end
      end
`ifdef WRPACK_PERF_EN
      total++;
      if (simd_cnt !== 16'(exp_simd) || single_cnt !== 16'(exp_single)) begin
         bad++;
         $display("FAIL %s perf_counts: got %0d/%0d want %0d/%0d",
                  name, simd_cnt, single_cnt, exp_simd, exp_single);
      end
`endif
   endtask

   task automatic check_outputs_zero(input string name);
      logic [127:0] v;
      v = {bus.pix_ready, bus.busy, bus.done, bus.write_en,
           bus.write_addr, bus.write_data, bus.simd_write_en,
           bus.simd_base_addr, bus.simd_data_0, bus.simd_data_1,
           bus.simd_data_2, bus.simd_data_3};
      total++;
      if (v !== '0) begin
         bad++;
         $display("FAIL %s outputs: got %0h want 0", name, v);
      end
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      bus.start      = 1'b0;
      bus.base_addr  = '0;
      bus.num_pixels = '0;
      bus.pix_valid  = 1'b0;
      bus.pix_data   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst_n = 1'b1;
   endtask

   task automatic test_aligned();
      pix_q.delete();
      for (int i = 1; i <= 8; i++) pix_q.push_back(8'(i));
      run_xfer(18'h00100, 8, 0, "aligned8");
   endtask

   task automatic test_unaligned();
      pix_q.delete();
      for (int i = 0; i < 7; i++) pix_q.push_back(8'hA0 + 8'(i));
      run_xfer(18'h00003, 7, 0, "unaligned7");
   endtask

   task automatic test_zero();
      pix_q.delete();
      run_xfer(18'h00040, 0, 0, "zero");
   endtask

   task automatic test_toggle();
      pix_q.delete();
      for (int i = 0; i < 4; i++) pix_q.push_back(8'h51 + 8'(i * 17));
      run_xfer(18'h00000, 4, 1, "toggle4");
   endtask

   task automatic test_reset_mid();
      int guard;
      pix_q.delete();
      for (int i = 0; i < 8; i++) pix_q.push_back(8'hC0 + 8'(i));
      @(posedge clk); #1;
      bus.start      = 1'b1;
      bus.base_addr  = 18'h00200;
      bus.num_pixels = CW'(8);
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.pix_valid = 1'b1;
      bus.pix_data  = pix_q[0];
      @(posedge clk); #1;
      bus.pix_data  = pix_q[1];
      @(posedge clk); #1;
      bus.pix_valid = 1'b0;
      clear_mon();
      #2 rst_n = 1'b0;
      #1 check_outputs_zero("reset_mid");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bus.pix_valid = 1'b1;
      guard = 0;
      while (guard < 10) begin
         @(posedge clk); #1;
         guard++;
      end
      bus.pix_valid = 1'b0;
      total++;
      if (obs_q.size() != 0 || done_cnt != 0 || acc_cnt != 0) begin
         bad++;
         $display("FAIL reset_mid quiet: got %0d writes %0d done %0d acc want 0",
                  obs_q.size(), done_cnt, acc_cnt);
      end
      test_aligned();
   endtask

   task automatic test_wrap();
      pix_q.delete();
      for (int i = 0; i < 8; i++) pix_q.push_back(8'h30 + 8'(i));
      run_xfer(18'h3FFFE, 8, 0, "wrap8");
   endtask

   task automatic test_random();
      logic [AW-1:0] base;
      int n;
      for (int t = 0; t < 12; t++) begin
         n = $urandom_range(0, 17);
         if (t % 3 == 0) base = AW'(18'h3FFFF - $urandom_range(0, 6));
         else            base = AW'($urandom);
         pix_q.delete();
         for (int i = 0; i < n; i++) pix_q.push_back(8'($urandom));
         run_xfer(base, n, 2, "random");
      end
   endtask

   task automatic test_perf();
`ifdef WRPACK_PERF_EN
      test_unaligned();
      total++;
      if (simd_cnt !== 16'd1 || single_cnt !== 16'd3) begin
         bad++;
         $display("FAIL perf_scn2: got %0d/%0d want 1/3", simd_cnt, single_cnt);
      end
      test_zero();
`endif
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_unaligned();
      test_zero();
      test_toggle();
      test_reset_mid();
      test_wrap();
      test_random();
      test_perf();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
